// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified memory between the IF stage (instruction fetch) and the
//   MEM stage (load/store). Only one transaction is outstanding at a time. The response is
//   steered back to the requester that owns it, and the stall signals are generated for
//   the hazard unit.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request (held until if_valid)
//   if_rdata/if_valid        fetch data / one-cycle completion pulse
//   stall_if                 IF must hold
//   dm_req/dm_we/dm_addr     data request (held until dm_valid)
//   dm_wdata/dm_wstrb        store data / byte enables
//   dm_rdata/dm_valid        load data / one-cycle completion pulse
//   stall_mem                MEM stage must hold
//   mem_req..mem_wstrb       registered memory command; mem_req is a one-cycle issue pulse
//   mem_rdata/mem_rvalid     memory response; mem_rvalid completes reads and writes
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stall_if,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [3:0]        dm_wstrb,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    localparam int unsigned      CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_wstrb_q;

    logic arb_point;
    logic if_starved;
    logic grant_dm;
    logic grant_if;

    // Arbitration happens whenever the port is free, including the completion cycle of the
    // current transaction so the next one can issue back-to-back.
    always_comb begin
        arb_point  = (state_q == StIdle) | mem_rvalid;
        if_starved = if_req & (starve_cnt_q == CNT_MAX);
        grant_dm   = arb_point & dm_req & ~if_starved;
        grant_if   = arb_point & ~grant_dm & if_req;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        if (arb_point) begin
            if (grant_dm) begin
                state_d = StBusyDm;
            end else if (grant_if) begin
                state_d = StBusyIf;
            end else begin
                state_d = StIdle;
            end

            // Count DM wins only while IF is actually waiting.
            if (!if_req || grant_if) begin
                starve_cnt_d = '0;
            end else if (grant_dm && starve_cnt_q != CNT_MAX) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    // Output logic. Valids are masked during reset so a response to an aborted
    // transaction never reaches a requester.
    always_comb begin
        if_valid  = ~rst & mem_rvalid & (state_q == StBusyIf);
        dm_valid  = ~rst & mem_rvalid & (state_q == StBusyDm);
        if_rdata  = mem_rdata;
        dm_rdata  = mem_rdata;
        stall_if  = if_req & ~if_valid;
        stall_mem = dm_req & ~dm_valid;
    end

    // Memory command register: loads from the winner on a grant and holds otherwise, so
    // the fields stay stable while the transaction is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'b0000;
        end else begin
            mem_req_q <= grant_dm | grant_if;
            if (grant_dm) begin
                mem_we_q    <= dm_we;
                mem_addr_q  <= dm_addr;
                mem_wdata_q <= dm_wdata;
                mem_wstrb_q <= dm_we ? dm_wstrb : 4'b0000;
            end else if (grant_if) begin
                mem_we_q    <= 1'b0;
                mem_addr_q  <= if_addr;
                mem_wdata_q <= '0;
                mem_wstrb_q <= 4'b0000;
            end
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              stall_if;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [3:0]        dm_wstrb;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;
    logic              stall_mem;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the memory, how many DM wins IF has sat through,
    // and the command the memory port should be presenting.
    int                m_owner;   // 0 none, 1 fetch, 2 data
    int                m_streak;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [3:0]        m_wstrb;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .stall_if  (stall_if),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_wstrb  (dm_wstrb),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .stall_mem (stall_mem),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid)
    );

    // Leaves the bench at a falling edge with rst low and the DUT idle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; dm_wstrb = 4'b0000; mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h44; dm_req = 1'b0; dm_we = 1'b1;
        dm_addr = 32'h88; dm_wdata = 32'hFFFF_FFFF; dm_wstrb = 4'hF;
        mem_rvalid = 1'b1; mem_rdata = 32'h1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (mem_wstrb !== 4'h0) begin failures++; $display("FAIL reset_mem_wstrb: got %h want 0", mem_wstrb); end
        checks++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin failures++; $display("FAIL reset_valids: got if=%0b dm=%0b want 0 0", if_valid, dm_valid); end
        checks++; if (stall_if !== 1'b1 || stall_mem !== 1'b0) begin failures++; $display("FAIL reset_stalls: got if=%0b mem=%0b want 1 0", stall_if, stall_mem); end
        dm_req = 1'b1;
        #1;
        checks++; if (stall_mem !== 1'b1) begin failures++; $display("FAIL reset_stall_mem_follows_req: got %0b want 1", stall_mem); end
        do_reset();
    endtask

    task automatic test_lone_load();
        do_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_wstrb = 4'b0000;
        #1;
        checks++; if (stall_mem !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL load_c0: got stall_mem=%0b mem_req=%0b want 1 0", stall_mem, mem_req); end
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL load_issue: got mem_req=%0b want 1", mem_req); end
        checks++; if (mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin failures++; $display("FAIL load_fields: got addr=%h we=%0b wstrb=%h want 100 0 0", mem_addr, mem_we, mem_wstrb); end
        checks++; if (stall_mem !== 1'b1) begin failures++; $display("FAIL load_stall_c1: got %0b want 1", stall_mem); end
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b0 || stall_mem !== 1'b1 || dm_valid !== 1'b0) begin failures++; $display("FAIL load_c2: got mem_req=%0b stall=%0b valid=%0b want 0 1 0", mem_req, stall_mem, dm_valid); end
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (dm_valid !== 1'b1 || dm_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_done: got valid=%0b rdata=%h want 1 deadbeef", dm_valid, dm_rdata); end
        checks++; if (stall_mem !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL load_done_side: got stall_mem=%0b if_valid=%0b want 0 0", stall_mem, if_valid); end
        dm_req = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || dm_valid !== 1'b0) begin failures++; $display("FAIL load_after: got mem_req=%0b dm_valid=%0b want 0 0", mem_req, dm_valid); end
    endtask

    task automatic test_store();
        do_reset();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h24; dm_wdata = 32'h1234_5678; dm_wstrb = 4'b0011;
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL store_issue: got req=%0b we=%0b want 1 1", mem_req, mem_we); end
        checks++; if (mem_addr !== 32'h24 || mem_wdata !== 32'h1234_5678 || mem_wstrb !== 4'b0011) begin failures++; $display("FAIL store_fields: got addr=%h wdata=%h wstrb=%h want 24 12345678 3", mem_addr, mem_wdata, mem_wstrb); end
        @(negedge clk);
        mem_rvalid = 1'b1;
        #1;
        checks++; if (dm_valid !== 1'b1 || if_valid !== 1'b0) begin failures++; $display("FAIL store_done: got dm_valid=%0b if_valid=%0b want 1 0", dm_valid, if_valid); end
        dm_req = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    task automatic test_contention();
        do_reset();
        if_req = 1'b1; if_addr = 32'h80;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h140;
        #1;
        checks++; if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin failures++; $display("FAIL cont_c0: got stall_if=%0b stall_mem=%0b want 1 1", stall_if, stall_mem); end
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h140) begin failures++; $display("FAIL cont_dm_first: got req=%0b addr=%h want 1 140", mem_req, mem_addr); end
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        #1;
        checks++; if (dm_valid !== 1'b1 || if_valid !== 1'b0 || stall_if !== 1'b1) begin failures++; $display("FAIL cont_dm_done: got dm_valid=%0b if_valid=%0b stall_if=%0b want 1 0 1", dm_valid, if_valid, stall_if); end
        dm_req = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80 || mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin failures++; $display("FAIL cont_if_issue: got req=%0b addr=%h we=%0b wstrb=%h want 1 80 0 0", mem_req, mem_addr, mem_we, mem_wstrb); end
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        #1;
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h13 || stall_if !== 1'b0 || dm_valid !== 1'b0) begin failures++; $display("FAIL cont_if_done: got valid=%0b rdata=%h stall=%0b dm_valid=%0b want 1 13 0 0", if_valid, if_rdata, stall_if, dm_valid); end
        if_req = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    // Both requesters stay busy; DM presents a fresh address on each completion and IF a
    // fresh address after each fetch. IF must win after every STARVE_MAX DM grants.
    task automatic test_starvation();
        logic [ADDR_W-1:0] seen[$];
        logic [ADDR_W-1:0] want[11];
        logic              rv_next;
        int                dm_next;
        want = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h1000,
                 32'h210, 32'h214, 32'h218, 32'h21C, 32'h1004, 32'h220};
        do_reset();
        if_req = 1'b1; if_addr = 32'h1000;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        rv_next = 1'b0;
        dm_next = 1;
        for (int cyc = 0; cyc < 200 && seen.size() < 11; cyc++) begin
            mem_rvalid = rv_next;
            mem_rdata  = 32'(cyc);
            #1;
            rv_next = mem_req;
            if (mem_req === 1'b1) seen.push_back(mem_addr);
            if (dm_valid === 1'b1) begin
                dm_addr = 32'h200 + 32'(4 * dm_next);
                dm_next++;
            end
            if (if_valid === 1'b1) if_addr = if_addr + 32'h4;
            @(negedge clk);
        end
        checks++;
        if (seen.size() != 11) begin
            failures++;
            $display("FAIL starve_issue_count: got %0d issues want 11", seen.size());
        end
        for (int i = 0; i < 11 && i < seen.size(); i++) begin
            checks++;
            if (seen[i] !== want[i]) begin
                failures++;
                $display("FAIL starve_order[%0d]: got addr %h want %h", i, seen[i], want[i]);
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        do_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_issue: got %0b want 1", mem_req); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (dm_valid !== 1'b0 || stall_mem !== 1'b1) begin failures++; $display("FAIL rstmid_in_rst: got dm_valid=%0b stall_mem=%0b want 0 1", dm_valid, stall_mem); end
        @(negedge clk);
        rst = 1'b0; dm_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        if_req = 1'b1; if_addr = 32'h400;
        #1;
        checks++; if (dm_valid !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL rstmid_late_rvalid: got dm_valid=%0b if_valid=%0b want 0 0", dm_valid, if_valid); end
        checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || stall_if !== 1'b1) begin failures++; $display("FAIL rstmid_cleared: got req=%0b addr=%h stall_if=%0b want 0 0 1", mem_req, mem_addr, stall_if); end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h400 || mem_we !== 1'b0) begin failures++; $display("FAIL rstmid_new_if: got req=%0b addr=%h we=%0b want 1 400 0", mem_req, mem_addr, mem_we); end
        @(negedge clk);
        mem_rvalid = 1'b1;
        #1;
        checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL rstmid_if_done: got %0b want 1", if_valid); end
        if_req = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    task automatic test_spurious();
        do_reset();
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        #1;
        checks++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin failures++; $display("FAIL spur_valids: got if=%0b dm=%0b want 0 0", if_valid, dm_valid); end
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b0 || if_valid !== 1'b0 || dm_valid !== 1'b0) begin failures++; $display("FAIL spur_c1: got req=%0b if=%0b dm=%0b want 0 0 0", mem_req, if_valid, dm_valid); end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL spur_c2: got req=%0b want 0", mem_req); end
    endtask

    task automatic test_drop_in_flight();
        do_reset();
        if_req = 1'b1; if_addr = 32'h500;
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin failures++; $display("FAIL drop_issue: got req=%0b addr=%h want 1 500", mem_req, mem_addr); end
        if_req = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_CAFE;
        #1;
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'hCAFE || stall_if !== 1'b0) begin failures++; $display("FAIL drop_done: got valid=%0b rdata=%h stall=%0b want 1 cafe 0", if_valid, if_rdata, stall_if); end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL drop_no_reissue: got req=%0b want 0", mem_req); end
    endtask

    // Advances the reference model across one rising edge using the current inputs.
    task automatic model_step();
        if (rst) begin
            m_owner = 0; m_streak = 0; m_req = 1'b0; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_wstrb = 4'b0000;
        end else begin
            m_req = 1'b0;
            if (m_owner == 0 || mem_rvalid) begin
                if (dm_req && !(if_req && m_streak == STARVE_MAX)) begin
                    m_streak = if_req ? ((m_streak < STARVE_MAX) ? m_streak + 1 : m_streak) : 0;
                    m_owner = 2; m_req = 1'b1; m_we = dm_we; m_addr = dm_addr;
                    m_wdata = dm_wdata; m_wstrb = dm_we ? dm_wstrb : 4'b0000;
                end else if (if_req) begin
                    m_streak = 0;
                    m_owner = 1; m_req = 1'b1; m_we = 1'b0; m_addr = if_addr; m_wstrb = 4'b0000;
                end else begin
                    m_streak = 0;
                    m_owner = 0;
                end
            end
        end
    endtask

    task automatic test_random();
        int   remaining;
        logic e_if_valid, e_dm_valid, e_stall_if, e_stall_mem;
        remaining = 0;
        @(negedge clk);
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; mem_rvalid = 1'b0;
        model_step();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (m_req) begin
                remaining = $urandom_range(1, 3);
                mem_rvalid = 1'b0;
            end else if (remaining > 0) begin
                remaining--;
                mem_rvalid = (remaining == 0);
            end else begin
                mem_rvalid = (m_owner == 0) && ($urandom_range(0, 7) == 0);
            end
            mem_rdata = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            #1;
            e_if_valid  = !rst && mem_rvalid && m_owner == 1;
            e_dm_valid  = !rst && mem_rvalid && m_owner == 2;
            e_stall_if  = if_req && !e_if_valid;
            e_stall_mem = dm_req && !e_dm_valid;
            checks++; if (mem_req !== m_req) begin failures++; $display("FAIL rnd_mem_req @%0d: got %0b want %0b", cyc, mem_req, m_req); end
            checks++; if (mem_addr !== m_addr) begin failures++; $display("FAIL rnd_mem_addr @%0d: got %h want %h", cyc, mem_addr, m_addr); end
            checks++; if (mem_we !== m_we) begin failures++; $display("FAIL rnd_mem_we @%0d: got %0b want %0b", cyc, mem_we, m_we); end
            checks++; if (mem_wstrb !== m_wstrb) begin failures++; $display("FAIL rnd_mem_wstrb @%0d: got %h want %h", cyc, mem_wstrb, m_wstrb); end
            if (m_we) begin
                checks++; if (mem_wdata !== m_wdata) begin failures++; $display("FAIL rnd_mem_wdata @%0d: got %h want %h", cyc, mem_wdata, m_wdata); end
            end
            checks++; if (if_valid !== e_if_valid) begin failures++; $display("FAIL rnd_if_valid @%0d: got %0b want %0b", cyc, if_valid, e_if_valid); end
            checks++; if (dm_valid !== e_dm_valid) begin failures++; $display("FAIL rnd_dm_valid @%0d: got %0b want %0b", cyc, dm_valid, e_dm_valid); end
            checks++; if (stall_if !== e_stall_if) begin failures++; $display("FAIL rnd_stall_if @%0d: got %0b want %0b", cyc, stall_if, e_stall_if); end
            checks++; if (stall_mem !== e_stall_mem) begin failures++; $display("FAIL rnd_stall_mem @%0d: got %0b want %0b", cyc, stall_mem, e_stall_mem); end
            if (e_if_valid) begin
                checks++; if (if_rdata !== mem_rdata) begin failures++; $display("FAIL rnd_if_rdata @%0d: got %h want %h", cyc, if_rdata, mem_rdata); end
            end
            if (e_dm_valid) begin
                checks++; if (dm_rdata !== mem_rdata) begin failures++; $display("FAIL rnd_dm_rdata @%0d: got %h want %h", cyc, dm_rdata, mem_rdata); end
            end
            // Requesters: on completion either retire or present the next request at once.
            if (e_if_valid) begin
                if ($urandom_range(0, 1) == 0) if_req = 1'b0;
                else if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (e_dm_valid) begin
                if ($urandom_range(0, 1) == 0) dm_req = 1'b0;
                else begin
                    dm_we = $urandom_range(0, 1) == 1; dm_addr = $urandom & 32'hFFFF_FFFC;
                    dm_wdata = $urandom; dm_wstrb = 4'($urandom);
                end
            end
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1'b1; dm_we = $urandom_range(0, 1) == 1; dm_addr = $urandom & 32'hFFFF_FFFC;
                dm_wdata = $urandom; dm_wstrb = 4'($urandom);
            end
            model_step();
        end
        do_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0;
        dm_wdata = '0; dm_wstrb = 4'b0000; mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset();
        test_lone_load();
        test_store();
        test_contention();
        test_starvation();
        test_reset_mid();
        test_spurious();
        test_drop_in_flight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
